div_req_ctrl: RTL and testbench
===============================

# div_req_ctrl

Initiator-side controller for the serial divider. It accepts one divide/remainder request at a time from the issue stage over a plain valid/ready interface and re-times it into the divider's delayed-valid input handshake: valid is raised the cycle after ready is observed, and the divider commits on valid alone. It collects the result into a one-entry writeback buffer, propagates flush, and reports the issue-to-result latency of the last completed operation.

## Interface
- WIDTH, 64, operand/result width
- LAT_W, 8, width of the latency counter (saturating)

- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- flush_i  in  1  kill all in-flight work
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_id_i  in  TRANS_ID_BITS  transaction id
- req_op_a_i / req_op_b_i  in  WIDTH  dividend / divisor
- req_opcode_i  in  2  0 udiv, 1 div, 2 urem, 3 rem
- div_in_rdy_i  in  1  divider idle
- div_in_vld_o  out  1  divider load strobe
- div_id_o, div_op_a_o, div_op_b_o, div_opcode_o  out  TRANS_ID_BITS/WIDTH/WIDTH/2  registered request fields
- div_flush_o  out  1  equals flush_i
- div_out_vld_i  in  1  divider result valid
- div_out_rdy_o  out  1  result accepted
- div_id_i  in  TRANS_ID_BITS; div_res_i  in  WIDTH  divider result
- wb_valid_o  out  1; wb_ready_i  in  1; wb_id_o  out  TRANS_ID_BITS; wb_result_o  out  WIDTH  writeback port
- last_lat_o  out  LAT_W  cycles from ISSUE to result capture, last op

## Operation
- States: IDLE, WAIT_RDY, ISSUE, BUSY.
- IDLE: req_ready_o=1 (0 if flush_i). Handshake latches id/operands/opcode into request regs -> WAIT_RDY.
- WAIT_RDY: div_in_rdy_i=1 -> ISSUE; else stay.
- ISSUE: div_in_vld_o=1 for exactly one cycle; latency counter cleared to 1 -> BUSY. div_in_vld_o is a pure function of state_q (no path from div_in_rdy_i).
- BUSY: div_out_rdy_o = !wb_valid_o | wb_ready_i. On div_out_vld_i & div_out_rdy_o: capture div_id_i/div_res_i into wb buffer, set wb_valid, copy counter to last_lat_o -> IDLE. Counter increments each BUSY cycle, saturates at all-ones.
- wb buffer: wb_valid clears on wb_ready_i unless a new capture occurs in the same cycle (capture wins, valid stays 1).
- Flush (any state): next state IDLE, request regs invalid, wb_valid cleared, div_out_rdy_o=0, any same-cycle result discarded, last_lat_o unchanged. A request presented with flush_i is not accepted.
- Opcode values pass through unchanged; no arithmetic on operands.

## Timing
- Reset values: state IDLE, div_in_vld_o=0, div_out_rdy_o=0, wb_valid_o=0, all data/id outputs 0, last_lat_o=0; req_ready_o=1 after reset deasserts.
- Request accepted at cycle t -> div_in_vld_o high at t+2 (if div_in_rdy_i high at t+1) -> state BUSY at t+3.
- Result handshake at cycle r -> wb_valid_o high at r+1; req_ready_o high at r+1.
- Request-reg outputs remain stable from t+1 through the ISSUE cycle.
- Only one operation outstanding; no request accepted outside IDLE.

## Structure
- State enum div_req_state_e and opcode constants (DIV_OP_UDIV=0, DIV_OP_DIV=1, DIV_OP_UREM=2, DIV_OP_REM=3) live in ariane_pkg alongside TRANS_ID_BITS.
- No sub-module; the wb buffer and saturating counter are inline.

## Test plan
- udiv a=100, b=7, id=3; divider model ready -> div_in_vld_o one cycle at t+2; wb_result_o=14, wb_id_o=3; last_lat_o equals model latency.
- div_in_rdy_i held low 5 cycles after accept -> stays WAIT_RDY, div_in_vld_o=0, operands stable; issues at cycle after rdy rises.
- wb_ready_i low while result 0x5 held and next result 0x9 arrives -> div_out_rdy_o=0 until 0x5 drained; no loss or duplication.
- flush_i during BUSY coinciding with div_out_vld_i -> wb_valid_o stays 0, div_flush_o=1, state IDLE next cycle, req_ready_o=1.
- Model latency 300 cycles with LAT_W=8 -> last_lat_o=255.
- rst_i asserted in BUSY -> all outputs at reset values immediately (asynchronous), no writeback after release.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared types and constants for the divider request controller.
package ariane_pkg;

  // Width of the transaction id carried with every request and result.
  localparam int TRANS_ID_BITS = 3;

  // Divider opcode encodings; passed through to the divider unchanged.
  localparam logic [1:0] DIV_OP_UDIV = 2'd0;
  localparam logic [1:0] DIV_OP_DIV  = 2'd1;
  localparam logic [1:0] DIV_OP_UREM = 2'd2;
  localparam logic [1:0] DIV_OP_REM  = 2'd3;

  // Controller state: accept, wait for divider idle, strobe, wait for result.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    ISSUE    = 2'd2,
    BUSY     = 2'd3
  } div_req_state_e;

endpackage

// File: rtl/div_req_ctrl_if.sv
// Bundle of issue, divider and writeback signals around div_req_ctrl.
// master = the controller, slave = the surrounding environment.
interface div_req_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int LAT_W = 8
);

  logic                              flush_i;
  logic                              req_valid_i;
  logic                              req_ready_o;
  logic [ariane_pkg::TRANS_ID_BITS-1:0] req_id_i;
  logic [WIDTH-1:0]                  req_op_a_i;
  logic [WIDTH-1:0]                  req_op_b_i;
  logic [1:0]                        req_opcode_i;
  logic                              div_in_rdy_i;
  logic                              div_in_vld_o;
  logic [ariane_pkg::TRANS_ID_BITS-1:0] div_id_o;
  logic [WIDTH-1:0]                  div_op_a_o;
  logic [WIDTH-1:0]                  div_op_b_o;
  logic [1:0]                        div_opcode_o;
  logic                              div_flush_o;
  logic                              div_out_vld_i;
  logic                              div_out_rdy_o;
  logic [ariane_pkg::TRANS_ID_BITS-1:0] div_id_i;
  logic [WIDTH-1:0]                  div_res_i;
  logic                              wb_valid_o;
  logic                              wb_ready_i;
  logic [ariane_pkg::TRANS_ID_BITS-1:0] wb_id_o;
  logic [WIDTH-1:0]                  wb_result_o;
  logic [LAT_W-1:0]                  last_lat_o;

  modport master (
    input  flush_i, req_valid_i, req_id_i, req_op_a_i, req_op_b_i, req_opcode_i,
           div_in_rdy_i, div_out_vld_i, div_id_i, div_res_i, wb_ready_i,
    output req_ready_o, div_in_vld_o, div_id_o, div_op_a_o, div_op_b_o,
           div_opcode_o, div_flush_o, div_out_rdy_o, wb_valid_o, wb_id_o,
           wb_result_o, last_lat_o
  );

  modport slave (
    output flush_i, req_valid_i, req_id_i, req_op_a_i, req_op_b_i, req_opcode_i,
           div_in_rdy_i, div_out_vld_i, div_id_i, div_res_i, wb_ready_i,
    input  req_ready_o, div_in_vld_o, div_id_o, div_op_a_o, div_op_b_o,
           div_opcode_o, div_flush_o, div_out_rdy_o, wb_valid_o, wb_id_o,
           wb_result_o, last_lat_o
  );

endinterface

// File: rtl/div_req_ctrl.sv
// Initiator-side controller for the serial divider: takes one request from
// the issue stage, re-times it into the divider's delayed-valid load strobe,
// buffers the result for writeback and records issue-to-result latency.
module div_req_ctrl
  import ariane_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LAT_W = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  div_req_ctrl_if.master bus
);

  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

  div_req_state_e             state_q, state_d;
  logic                       accept;
  logic                       capture;
  logic                       out_rdy;
  logic                       req_ready;

  logic [TRANS_ID_BITS-1:0]   id_q;
  logic [WIDTH-1:0]           op_a_q;
  logic [WIDTH-1:0]           op_b_q;
  logic [1:0]                 opcode_q;

  logic [LAT_W-1:0]           lat_cnt_q;
  logic [LAT_W-1:0]           last_lat_q;

  logic                       wb_valid_q;
  logic [TRANS_ID_BITS-1:0]   wb_id_q;
  logic [WIDTH-1:0]           wb_result_q;

  // Next-state and handshake decode; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    out_rdy   = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !bus.flush_i;
        if (bus.req_valid_i && !bus.flush_i) begin
          accept  = 1'b1;
          state_d = WAIT_RDY;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RDY: begin
        if (bus.div_in_rdy_i) begin
          state_d = ISSUE;
        end else begin
          state_d = WAIT_RDY;
        end
      end
      ISSUE: begin
        state_d = BUSY;
      end
      BUSY: begin
        out_rdy = (!wb_valid_q || bus.wb_ready_i) && !bus.flush_i;
        if (bus.div_out_vld_i && out_rdy) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields latched on accept and held until the next accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= 2'd0;
    end else if (accept) begin
      id_q     <= bus.req_id_i;
      op_a_q   <= bus.req_op_a_i;
      op_b_q   <= bus.req_op_b_i;
      opcode_q <= bus.req_opcode_i;
    end
  end

  // Latency counter: starts at 1 after the strobe, saturating count in BUSY.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      lat_cnt_q <= LAT_ONE;
    end else if (state_q == BUSY && lat_cnt_q != LAT_MAX) begin
      lat_cnt_q <= lat_cnt_q + LAT_ONE;
    end
  end

  // One-entry writeback buffer; a new capture wins over a same-cycle drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_q  <= 1'b0;
      wb_id_q     <= '0;
      wb_result_q <= '0;
      last_lat_q  <= '0;
    end else if (bus.flush_i) begin
      wb_valid_q  <= 1'b0;
    end else if (capture) begin
      wb_valid_q  <= 1'b1;
      wb_id_q     <= bus.div_id_i;
      wb_result_q <= bus.div_res_i;
      last_lat_q  <= lat_cnt_q;
    end else if (bus.wb_ready_i) begin
      wb_valid_q  <= 1'b0;
    end
  end

  assign bus.req_ready_o   = req_ready;
  assign bus.div_in_vld_o  = (state_q == ISSUE);
  assign bus.div_id_o      = id_q;
  assign bus.div_op_a_o    = op_a_q;
  assign bus.div_op_b_o    = op_b_q;
  assign bus.div_opcode_o  = opcode_q;
  assign bus.div_flush_o   = bus.flush_i;
  assign bus.div_out_rdy_o = out_rdy;
  assign bus.wb_valid_o    = wb_valid_q;
  assign bus.wb_id_o       = wb_id_q;
  assign bus.wb_result_o   = wb_result_q;
  assign bus.last_lat_o    = last_lat_q;

endmodule

// File: tb/tb_div_req_ctrl.sv
// Directed self-checking bench for div_req_ctrl. Inputs change on the
// falling edge; outputs are checked on the falling edge (combinational
// outputs #1 after inputs change).
module tb_div_req_ctrl;
  import ariane_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div_req_ctrl_if #(.WIDTH(64), .LAT_W(8)) bus ();

  div_req_ctrl #(.WIDTH(64), .LAT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [2:0] id, input logic [63:0] a,
                           input logic [63:0] b, input logic [1:0] op);
    bus.req_valid_i  = 1'b1;
    bus.req_id_i     = id;
    bus.req_op_a_i   = a;
    bus.req_op_b_i   = b;
    bus.req_opcode_i = op;
  endtask

  // Directed test sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_id_i = 3'd0;
    bus.req_op_a_i = 64'd0;
    bus.req_op_b_i = 64'd0;
    bus.req_opcode_i = 2'd0;
    bus.div_in_rdy_i = 1'b1;
    bus.div_out_vld_i = 1'b0;
    bus.div_id_i = 3'd0;
    bus.div_res_i = 64'd0;
    bus.wb_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_in_vld", bus.div_in_vld_o, 64'd0);
    chk("rst_out_rdy", bus.div_out_rdy_o, 64'd0);
    chk("rst_wb_valid", bus.wb_valid_o, 64'd0);
    chk("rst_last_lat", bus.last_lat_o, 64'd0);
    chk("rst_wb_result", bus.wb_result_o, 64'd0);
    chk("rst_div_id", bus.div_id_o, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready_o, 64'd1);

    // udiv 100/7 id 3, divider ready, result after 4 counted cycles
    @(negedge clk);
    drive_req(3'd3, 64'd100, 64'd7, DIV_OP_UDIV);
    #1;
    chk("t1_req_ready", bus.req_ready_o, 64'd1);
    tick();                                   // accepted
    bus.req_valid_i = 1'b0;
    #1;
    chk("t1_ready_low", bus.req_ready_o, 64'd0);
    chk("t1_vld_t1", bus.div_in_vld_o, 64'd0);
    chk("t1_op_a", bus.div_op_a_o, 64'd100);
    chk("t1_op_b", bus.div_op_b_o, 64'd7);
    chk("t1_id", bus.div_id_o, 64'd3);
    tick();                                   // ISSUE
    chk("t1_vld_t2", bus.div_in_vld_o, 64'd1);
    bus.div_in_rdy_i = 1'b0;
    tick();                                   // BUSY, count 1
    chk("t1_vld_t3", bus.div_in_vld_o, 64'd0);
    chk("t1_busy_rdy", bus.div_out_rdy_o, 64'd1);
    tick();
    tick();
    tick();                                   // count 4
    bus.div_out_vld_i = 1'b1;
    bus.div_id_i = 3'd3;
    bus.div_res_i = 64'd14;
    tick();
    bus.div_out_vld_i = 1'b0;
    bus.div_in_rdy_i = 1'b1;
    chk("t1_wb_valid", bus.wb_valid_o, 64'd1);
    chk("t1_wb_result", bus.wb_result_o, 64'd14);
    chk("t1_wb_id", bus.wb_id_o, 64'd3);
    chk("t1_last_lat", bus.last_lat_o, 64'd4);
    #1;
    chk("t1_req_ready_after", bus.req_ready_o, 64'd1);
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    chk("t1_wb_drain", bus.wb_valid_o, 64'd0);

    // Divider busy for 5 cycles after accept
    bus.div_in_rdy_i = 1'b0;
    drive_req(3'd5, 64'hDEAD, 64'h11, DIV_OP_REM);
    tick();
    bus.req_valid_i = 1'b0;
    bus.req_op_a_i = 64'h1234;
    for (int i = 0; i < 5; i++) begin
      chk("t2_wait_vld", bus.div_in_vld_o, 64'd0);
      chk("t2_wait_op_a", bus.div_op_a_o, 64'hDEAD);
      tick();
    end
    chk("t2_opcode", bus.div_opcode_o, {62'd0, DIV_OP_REM});
    bus.div_in_rdy_i = 1'b1;
    #1;
    chk("t2_vld_pre", bus.div_in_vld_o, 64'd0);
    tick();
    chk("t2_vld_issue", bus.div_in_vld_o, 64'd1);
    chk("t2_op_b_issue", bus.div_op_b_o, 64'h11);
    tick();
    chk("t2_vld_busy", bus.div_in_vld_o, 64'd0);
    bus.div_out_vld_i = 1'b1;
    bus.div_id_i = 3'd5;
    bus.div_res_i = 64'h5;
    tick();
    bus.div_out_vld_i = 1'b0;
    chk("t2_wb_result", bus.wb_result_o, 64'h5);
    chk("t2_last_lat", bus.last_lat_o, 64'd1);

    // Back-pressure: 0x5 held, 0x9 arrives
    drive_req(3'd6, 64'd1, 64'd2, DIV_OP_UREM);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    tick();                                   // BUSY, count 1
    bus.div_out_vld_i = 1'b1;
    bus.div_id_i = 3'd6;
    bus.div_res_i = 64'h9;
    #1;
    chk("t3_out_rdy_blocked", bus.div_out_rdy_o, 64'd0);
    tick();
    chk("t3_hold_result", bus.wb_result_o, 64'h5);
    chk("t3_hold_id", bus.wb_id_o, 64'd5);
    chk("t3_out_rdy_still", bus.div_out_rdy_o, 64'd0);
    tick();                                   // count 3
    bus.wb_ready_i = 1'b1;
    #1;
    chk("t3_out_rdy_open", bus.div_out_rdy_o, 64'd1);
    tick();
    bus.div_out_vld_i = 1'b0;
    chk("t3_wb_valid", bus.wb_valid_o, 64'd1);
    chk("t3_wb_result", bus.wb_result_o, 64'h9);
    chk("t3_wb_id", bus.wb_id_o, 64'd6);
    chk("t3_last_lat", bus.last_lat_o, 64'd3);
    tick();
    bus.wb_ready_i = 1'b0;
    chk("t3_no_dup", bus.wb_valid_o, 64'd0);

    // Flush during BUSY with a coincident result
    drive_req(3'd7, 64'd50, 64'd5, DIV_OP_DIV);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    tick();
    bus.div_out_vld_i = 1'b1;
    bus.div_id_i = 3'd7;
    bus.div_res_i = 64'd10;
    bus.flush_i = 1'b1;
    #1;
    chk("t4_div_flush", bus.div_flush_o, 64'd1);
    chk("t4_out_rdy", bus.div_out_rdy_o, 64'd0);
    tick();
    bus.flush_i = 1'b0;
    bus.div_out_vld_i = 1'b0;
    #1;
    chk("t4_wb_valid", bus.wb_valid_o, 64'd0);
    chk("t4_last_lat_kept", bus.last_lat_o, 64'd3);
    chk("t4_req_ready", bus.req_ready_o, 64'd1);
    // request under flush is refused
    drive_req(3'd2, 64'd8, 64'd4, DIV_OP_UDIV);
    bus.flush_i = 1'b1;
    #1;
    chk("t4_flush_ready", bus.req_ready_o, 64'd0);
    tick();
    bus.flush_i = 1'b0;
    bus.req_valid_i = 1'b0;
    chk("t4_id_unchanged", bus.div_id_o, 64'd7);
    tick();
    chk("t4_no_issue", bus.div_in_vld_o, 64'd0);

    // Saturating latency: 300 cycles -> 255
    drive_req(3'd1, 64'd9, 64'd3, DIV_OP_UDIV);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    tick();                                   // BUSY, count 1
    for (int i = 0; i < 299; i++) tick();
    bus.div_out_vld_i = 1'b1;
    bus.div_id_i = 3'd1;
    bus.div_res_i = 64'd3;
    tick();
    bus.div_out_vld_i = 1'b0;
    chk("t5_last_lat_sat", bus.last_lat_o, 64'd255);
    chk("t5_wb_result", bus.wb_result_o, 64'd3);
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;

    // Asynchronous reset while BUSY
    drive_req(3'd4, 64'd77, 64'd11, DIV_OP_DIV);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    tick();
    bus.div_out_vld_i = 1'b1;
    bus.div_id_i = 3'd4;
    bus.div_res_i = 64'd7;
    rst = 1'b1;
    #1;
    chk("t6_rst_div_id", bus.div_id_o, 64'd0);
    chk("t6_rst_op_a", bus.div_op_a_o, 64'd0);
    chk("t6_rst_last_lat", bus.last_lat_o, 64'd0);
    chk("t6_rst_wb_result", bus.wb_result_o, 64'd0);
    chk("t6_rst_out_rdy", bus.div_out_rdy_o, 64'd0);
    chk("t6_rst_req_ready", bus.req_ready_o, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t6_no_wb", bus.wb_valid_o, 64'd0);
    bus.div_out_vld_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
